uart16550_rx_ovs: RTL and testbench
===================================

# uart16550_rx_ovs

Parametrised successor to the 16550-style UART receiver. It converts a serial `rx` line into characters using a configurable oversampling ratio, with three-sample majority voting at mid-bit, false-start rejection and break/frame/parity detection. Received characters and their per-character status go into an internal first-word-fall-through FIFO. The block sits between the baud generator (`baud_pulse`) and the line-status/receive-buffer register logic, which drains the FIFO through a valid/ready handshake.

## Interface
- `OVS`, default 16: `baud_pulse` ticks per bit. Even, ≥ 4.
- `FIFO_DEPTH`, default 4: number of character entries. Power of 2, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `baud_pulse`  in  1  one-clk strobe at OVS × baud rate.
- `rx`  in  1  asynchronous serial input, idle high.
- `pen`  in  1  parity enable.
- `eps`  in  1  even parity select.
- `sticky_parity`  in  1  stick parity.
- `wls`  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- `rx_data`  out  8  FIFO head character, LSB = first bit received; unused upper bits are 0.
- `rx_pe`, `rx_fe`, `rx_bi`  out  1 each  head-entry parity error, framing error and break.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid & rx_ready`.
- `overrun`  out  1  one-clk pulse when a completed character is dropped.
- `busy`  out  1  FSM is not in IDLE.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- `rx` passes through a 2-flop synchronizer (flops reset to 1), giving `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- Tick counter counts `baud_pulse` from 0 to OVS−1 within each bit. Votes are taken at ticks OVS/2−1, OVS/2 and OVS/2+1. The bit value is the 2-of-3 majority, decided at tick OVS/2+1.
- IDLE: on a `baud_pulse` with `rx_s`=0, go to START with tick counter = 0. On this same cycle, latch `pen`, `eps`, `sticky_parity` and `wls`. Changes to these inputs mid-frame have no effect.
- START: if the vote is 1, it is a false start; return to IDLE with no push. If the vote is 0, go to DATA at the end of the bit (tick OVS−1).
- DATA: shift in N = 5 + wls bits, LSB first. After bit N, go to PARITY if pen, otherwise go to STOP.
- PARITY expected bit:
  - sticky_parity=1: expected = ~eps.
  - sticky_parity=0, eps=1: expected = ^data.
  - sticky_parity=0, eps=0: expected = ~^data.
  - pe = received ≠ expected. pe = 0 when pen = 0.
- STOP: only the first stop bit is checked. At the vote decision:
  - fe = (vote == 0).
  - bi = 1 when all data bits, the parity bit (if enabled) and the stop bit all voted 0. In that case pe and fe are forced to {pe=0, fe=1}.
  - Push the entry {bi, fe, pe, data}.
  - Next state: BRK_WAIT if bi, otherwise IDLE. IDLE is entered immediately, at mid-stop-bit, so a following start edge can be caught.
- BRK_WAIT: stay until `rx_s`=1 on a `baud_pulse`, then go to IDLE. A held-low line therefore produces exactly one break entry.
- FIFO behaviour:
  - Push when not full. Push when full with a pop in the same cycle: both succeed and `level` is unchanged.
  - Push when full with no pop: the entry is dropped, `overrun`=1 for that cycle, and the FIFO contents are untouched.
  - A pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `rx_data`=0, `rx_pe`=`rx_fe`=`rx_bi`=0, `rx_valid`=0, `overrun`=0, `busy`=0, `level`=0. The FSM is in IDLE and the synchronizer holds 1.
- Reset asserted mid-frame aborts the frame, clears the FIFO and emits no `overrun`.
- Latency from an `rx` edge to `rx_s` is 2 clk.
- The FIFO write is registered on the clk edge of the stop-bit decision `baud_pulse`. From the next cycle, `rx_valid`=1 and the head outputs show the entry (first-word-fall-through).
- A pop takes effect at the clock edge. The next entry, or `rx_valid`=0, is visible the following cycle.
- `busy` rises the cycle after start detection and falls the cycle after the return to IDLE.

## Test plan
- **Nominal 8E1 frame:** OVS=16, wls=11, pen=1, eps=1, sticky=0, send 0x45 with parity bit 1 and a stop bit. Expect one entry: `rx_data`=0x45, pe=fe=bi=0, `level`=1. Pop with `rx_ready` → `rx_valid`=0 and `level`=0.
- **Parity error and framing error:** send the same frame with parity bit 0 → pe=1. Send 0xA3 with the stop bit driven 0 → fe=1, bi=0, `rx_data`=0xA3.
- **Break:** hold `rx`=0 for 15 bit times, then return it high. Expect exactly one entry: `rx_data`=0x00, bi=1, fe=1, pe=0. A subsequent 0x5A frame is received correctly.
- **False start and glitch rejection:** a `rx`=0 glitch lasting 3 `baud_pulse` → no push and `busy` returns to 0. A single-tick glitch at the mid-bit of a data bit leaves the voted value unchanged.
- **Overrun:** FIFO_DEPTH=4, `rx_ready`=0, send 5 frames 0x01 through 0x05. Expect `overrun` pulsed once and `level`=4. Pops return 0x01 to 0x04 in order.
- **Five-bit stick parity with OVS=8:** wls=00, pen=1, sticky=1, eps=0 (expected parity bit 1), send 0x1F → `rx_data`=0x1F, pe=0. Repeat with eps changed mid-frame → no effect on the result.

Source files
------------

// File: rtl/uart16550_rx_ovs.sv
// Oversampling 16550-style UART receiver: majority-voted bit sampling, break/frame/parity
// detection, and a first-word-fall-through FIFO of characters with per-character status.
module uart16550_rx_ovs #(
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_pulse,
  input  logic                          rx,
  input  logic                          pen,
  input  logic                          eps,
  input  logic                          sticky_parity,
  input  logic [1:0]                    wls,
  output logic [7:0]                    rx_data,
  output logic                          rx_pe,
  output logic                          rx_fe,
  output logic                          rx_bi,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = $clog2(OVS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] T_V0  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] T_V1  = CW'(OVS / 2);
  localparam logic [CW-1:0] T_DEC = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] T_END = CW'(OVS - 1);
  localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t        state;
  logic          rx_meta, rx_s;
  logic [CW-1:0] tick, tick_nxt;
  logic          s0, s1, vote, at_dec;
  logic [2:0]    bit_cnt, last_bit;
  logic [7:0]    data;
  logic          pen_l, eps_l, sp_l;
  logic [1:0]    wls_l;
  logic          all_zero, pe_r, exp_par, stop_bi, push;
  logic [10:0]   entry;

  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, pop, wr_en;
  logic [10:0]   head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The tick value "of" a baud_pulse is tick_nxt, so detection is tick 0 and votes land mid-bit.
  always_comb begin
    tick_nxt = (tick == T_END) ? '0 : tick + 1'b1;
    vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    at_dec   = baud_pulse && (tick_nxt == T_DEC);
    last_bit = {1'b0, wls_l} + 3'd4;
    exp_par  = sp_l ? ~eps_l : (eps_l ? ^data : ~^data);
    stop_bi  = all_zero & ~vote;
    push     = at_dec && (state == STOP);
    entry    = {stop_bi, ~vote, pe_r & ~stop_bi, data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tick     <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      bit_cnt  <= '0;
      data     <= '0;
      pen_l    <= 1'b0;
      eps_l    <= 1'b0;
      sp_l     <= 1'b0;
      wls_l    <= '0;
      all_zero <= 1'b0;
      pe_r     <= 1'b0;
    end else if (baud_pulse) begin
      if (state != IDLE && state != BRK_WAIT) begin
        tick <= tick_nxt;
        if (tick_nxt == T_V0) s0 <= rx_s;
        if (tick_nxt == T_V1) s1 <= rx_s;
      end
      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          tick     <= '0;
          pen_l    <= pen;
          eps_l    <= eps;
          sp_l     <= sticky_parity;
          wls_l    <= wls;
          data     <= '0;
          bit_cnt  <= '0;
          all_zero <= 1'b1;
          pe_r     <= 1'b0;
        end
        START: begin
          if (tick_nxt == T_DEC && vote) state <= IDLE;
          else if (tick_nxt == T_END)    state <= DATA;
        end
        DATA: begin
          if (tick_nxt == T_DEC) begin
            data[bit_cnt] <= vote;
            if (vote) all_zero <= 1'b0;
          end
          if (tick_nxt == T_END) begin
            if (bit_cnt == last_bit) state <= pen_l ? PARITY : STOP;
            else                     bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (tick_nxt == T_DEC) begin
            pe_r <= (vote != exp_par);
            if (vote) all_zero <= 1'b0;
          end
          if (tick_nxt == T_END) state <= STOP;
        end
        STOP: if (tick_nxt == T_DEC) state <= stop_bi ? BRK_WAIT : IDLE;
        BRK_WAIT: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign rx_valid = (count != '0);
  assign full     = (count == FULL);
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);
  assign head     = mem[rd_ptr];
  assign rx_data  = rx_valid ? head[7:0] : 8'h00;
  assign rx_pe    = rx_valid & head[8];
  assign rx_fe    = rx_valid & head[9];
  assign rx_bi    = rx_valid & head[10];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  // A full FIFO with a simultaneous pop frees the head slot, so the new entry still lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart16550_rx_ovs.sv
// Directed bench for uart16550_rx_ovs: one OVS=16 instance and one OVS=8 instance share
// the serial line and configuration; baud_pulse fires every second clock.
module tb_uart16550_rx_ovs;

  logic       clk = 1'b0, rst = 1'b0, baud_pulse = 1'b0, rx = 1'b1;
  logic       pen = 1'b0, eps = 1'b0, sticky_parity = 1'b0, rx_ready = 1'b0;
  logic [1:0] wls = 2'b00;

  logic [7:0] rx_data, rx_data8;
  logic       rx_pe, rx_fe, rx_bi, rx_valid, overrun, busy;
  logic       rx_pe8, rx_fe8, rx_bi8, rx_valid8, overrun8, busy8;
  logic [2:0] level, level8;

  int checks = 0, errors = 0, ovr_count = 0;

  uart16550_rx_ovs #(.OVS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .wls(wls), .rx_data(rx_data), .rx_pe(rx_pe),
    .rx_fe(rx_fe), .rx_bi(rx_bi), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .busy(busy), .level(level));

  uart16550_rx_ovs #(.OVS(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .wls(wls), .rx_data(rx_data8), .rx_pe(rx_pe8),
    .rx_fe(rx_fe8), .rx_bi(rx_bi8), .rx_valid(rx_valid8), .rx_ready(rx_ready),
    .overrun(overrun8), .busy(busy8), .level(level8));

  always #5 clk = ~clk;

  initial forever @(negedge clk) baud_pulse = ~baud_pulse;

  initial forever @(negedge clk) if (overrun === 1'b1) ovr_count = ovr_count + 1;

  task automatic do_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // A glitched bit is inverted for one baud_pulse period centred on the bit.
  task automatic send_bit(input logic b, input int clks, input logic glitch);
    rx = b;
    if (glitch) begin
      repeat (clks / 2 - 1) @(negedge clk);
      rx = ~b;
      repeat (2) @(negedge clk);
      rx = b;
      repeat (clks / 2 - 1) @(negedge clk);
    end else begin
      repeat (clks) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int ovs, input logic [7:0] d, input int n, input logic par_en,
                            input logic par_bit, input logic stop_bit, input int glitch_idx);
    int clks;
    clks = 2 * ovs;
    send_bit(1'b0, clks, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], clks, i == glitch_idx);
    if (par_en) send_bit(par_bit, clks, 1'b0);
    send_bit(stop_bit, clks, 1'b0);
    send_bit(1'b1, 2 * clks, 1'b0);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %0h, expected 0", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b, expected 000", {rx_pe, rx_fe, rx_bi}); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, expected 0", level); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b, expected 1", busy); end
    ovr_count = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
    rst = 1'b1;
    repeat (96) @(negedge clk);
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL midreset_level: got %0d, expected 0", level); end
    checks++; if (ovr_count !== 0) begin errors++; $display("[TB] FAIL midreset_overrun: got %0d, expected 0", ovr_count); end
  endtask

  task automatic test_nominal();
    pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0; wls = 2'b11;
    send_frame(16, 8'h45, 8, 1'b1, 1'b1, 1'b1, -1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL nominal_valid: got %b, expected 1", rx_valid); end
    checks++; if (rx_data !== 8'h45) begin errors++; $display("[TB] FAIL nominal_data: got %0h, expected 45", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b000) begin errors++; $display("[TB] FAIL nominal_status: got %b, expected 000", {rx_pe, rx_fe, rx_bi}); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL nominal_level: got %0d, expected 1", level); end
    pop();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_pop_valid: got %b, expected 0", rx_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL nominal_pop_level: got %0d, expected 0", level); end
  endtask

  task automatic test_parity_framing();
    send_frame(16, 8'h45, 8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (rx_data !== 8'h45) begin errors++; $display("[TB] FAIL pe_data: got %0h, expected 45", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b100) begin errors++; $display("[TB] FAIL pe_status: got %b, expected 100", {rx_pe, rx_fe, rx_bi}); end
    pop();
    send_frame(16, 8'hA3, 8, 1'b1, 1'b0, 1'b0, -1);
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("[TB] FAIL fe_data: got %0h, expected a3", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b010) begin errors++; $display("[TB] FAIL fe_status: got %b, expected 010", {rx_pe, rx_fe, rx_bi}); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL fe_level: got %0d, expected 1", level); end
    pop();
  endtask

  task automatic test_break();
    rx = 1'b0;
    repeat (15 * 32) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL break_level: got %0d, expected 1", level); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL break_data: got %0h, expected 0", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b011) begin errors++; $display("[TB] FAIL break_status: got %b, expected 011", {rx_pe, rx_fe, rx_bi}); end
    pop();
    send_frame(16, 8'h5A, 8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("[TB] FAIL after_break_data: got %0h, expected 5a", rx_data); end
    checks++; if ({rx_pe, rx_fe, rx_bi} !== 3'b000) begin errors++; $display("[TB] FAIL after_break_status: got %b, expected 000", {rx_pe, rx_fe, rx_bi}); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL after_break_level: got %0d, expected 1", level); end
    pop();
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL false_start_busy_high: got %b, expected 1", busy); end
    repeat (64) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL false_start_busy_low: got %b, expected 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL false_start_level: got %0d, expected 0", level); end
    send_frame(16, 8'h45, 8, 1'b1, 1'b1, 1'b1, 0);
    checks++; if (rx_data !== 8'h45) begin errors++; $display("[TB] FAIL glitch_one_data: got %0h, expected 45", rx_data); end
    checks++; if (rx_pe !== 1'b0) begin errors++; $display("[TB] FAIL glitch_one_pe: got %b, expected 0", rx_pe); end
    pop();
    send_frame(16, 8'h45, 8, 1'b1, 1'b1, 1'b1, 3);
    checks++; if (rx_data !== 8'h45) begin errors++; $display("[TB] FAIL glitch_zero_data: got %0h, expected 45", rx_data); end
    pop();
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    ovr_count = 0;
    for (int v = 1; v <= 5; v++) send_frame(16, 8'(v), 8, 1'b1, ^(8'(v)), 1'b1, -1);
    checks++; if (ovr_count !== 1) begin errors++; $display("[TB] FAIL overrun_pulses: got %0d, expected 1", ovr_count); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL overrun_level: got %0d, expected 4", level); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rx_data !== 8'(i)) begin errors++; $display("[TB] FAIL overrun_order: got %0h, expected %0h", rx_data, i); end
      pop();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_drained: got %b, expected 0", rx_valid); end
  endtask

  task automatic test_stick_ovs8();
    do_reset();
    pen = 1'b1; sticky_parity = 1'b1; eps = 1'b0; wls = 2'b00;
    send_frame(8, 8'h1F, 5, 1'b1, 1'b1, 1'b1, -1);
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("[TB] FAIL stick_valid: got %b, expected 1", rx_valid8); end
    checks++; if (rx_data8 !== 8'h1F) begin errors++; $display("[TB] FAIL stick_data: got %0h, expected 1f", rx_data8); end
    checks++; if ({rx_pe8, rx_fe8, rx_bi8} !== 3'b000) begin errors++; $display("[TB] FAIL stick_status: got %b, expected 000", {rx_pe8, rx_fe8, rx_bi8}); end
    pop();
    fork
      send_frame(8, 8'h1F, 5, 1'b1, 1'b1, 1'b1, -1);
      begin
        repeat (48) @(negedge clk);
        eps = 1'b1;
      end
    join
    checks++; if (rx_data8 !== 8'h1F) begin errors++; $display("[TB] FAIL stick_midframe_data: got %0h, expected 1f", rx_data8); end
    checks++; if (rx_pe8 !== 1'b0) begin errors++; $display("[TB] FAIL stick_midframe_pe: got %b, expected 0", rx_pe8); end
    pop();
    send_frame(8, 8'h1F, 5, 1'b1, 1'b1, 1'b1, -1);
    checks++; if (rx_pe8 !== 1'b1) begin errors++; $display("[TB] FAIL stick_eps1_pe: got %b, expected 1", rx_pe8); end
    checks++; if (level8 !== 3'd1) begin errors++; $display("[TB] FAIL stick_level: got %0d, expected 1", level8); end
    pop();
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_nominal();
    test_parity_framing();
    test_break();
    test_false_start();
    test_overrun();
    test_stick_ovs8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
